// File: rtl/full_adder_4bits.sv
// N-bit ripple-carry adder leaf.
// The combinational sum and carry come straight from a chain of one-bit cells.
// A registered copy of the result is kept alongside it, together with a
// signed-overflow flag and a zero flag.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  // Propagate term, shared by the sum and carry equations.
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

module full_adder_4bits #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic [N-1:0] s_q,
  output logic         cout_q,
  output logic         ovf_q,
  output logic         zero_q
);

  // c[i] is the carry into bit i; c[N] is the carry out of the MSB.
  logic [N:0] c;
  logic       ovf;
  logic       zero;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_cell
    full_adder_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign cout = c[N];

  // Two's-complement overflow: the carry into the MSB disagrees with the carry out of it.
  // When N=1 the carry into the MSB is cin itself.
  assign ovf  = c[N] ^ c[N-1];

  // Zero looks only at the N-bit sum; a wrap-around carry still counts as zero.
  assign zero = (s == '0);

  // Capture the result and its flags each cycle; reset clears them immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      s_q    <= s;
      cout_q <= cout;
      ovf_q  <= ovf;
      zero_q <= zero;
    end
  end

endmodule

// File: tb/tb_full_adder_4bits.sv
// Self-checking bench for full_adder_4bits.
// It covers the exhaustive combinational sweep, a table of corner vectors, the
// registered path, asynchronous reset and its release, and a randomized run
// that is compared against a signed/unsigned arithmetic reference model.
`timescale 1ns/1ps

module tb_full_adder_4bits;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic [N-1:0] s;
  logic         cout;
  logic [N-1:0] s_q;
  logic         cout_q;
  logic         ovf_q;
  logic         zero_q;

  logic clk_run;
  int   n_cmp;
  int   n_bad;

  typedef struct {
    logic [N-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;
  } result_t;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] exp_s;
    logic         exp_cout;
  } vec_t;

  vec_t corners[6];

  full_adder_4bits #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .s      (s),
    .cout   (cout),
    .s_q    (s_q),
    .cout_q (cout_q),
    .ovf_q  (ovf_q),
    .zero_q (zero_q)
  );

  // The clock only toggles once clk_run is set, so the combinational sweep can run with clk idle.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  // Reference model: the unsigned sum gives s and cout, and the signed-range check gives ovf.
  function automatic result_t model(input logic [N-1:0] ma, input logic [N-1:0] mb, input logic mc);
    result_t r;
    int usum;
    int sa;
    int sb;
    int ssum;
    usum = int'(ma) + int'(mb) + int'(mc);
    sa   = ma[N-1] ? int'(ma) - (1 << N) : int'(ma);
    sb   = mb[N-1] ? int'(mb) - (1 << N) : int'(mb);
    ssum = sa + sb + int'(mc);
    r.s    = N'(usum % (1 << N));
    r.cout = (usum >= (1 << N));
    r.ovf  = (ssum > (1 << (N-1)) - 1) || (ssum < -(1 << (N-1)));
    r.zero = (r.s == '0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (a=%0d b=%0d cin=%0d t=%0t)",
               name, act, exp, a, b, cin, $time);
    end
  endtask

  task automatic chk_regs(input string tag, input logic [N-1:0] es, input logic ec,
                          input logic eo, input logic ez);
    chk({tag, ".s_q"},    32'(s_q),    32'(es));
    chk({tag, ".cout_q"}, 32'(cout_q), 32'(ec));
    chk({tag, ".ovf_q"},  32'(ovf_q),  32'(eo));
    chk({tag, ".zero_q"}, 32'(zero_q), 32'(ez));
  endtask

  task automatic apply(input logic [N-1:0] ta, input logic [N-1:0] tb_, input logic tc);
    a   = ta;
    b   = tb_;
    cin = tc;
  endtask

  // Waits for a rising edge and then samples 1 ns later, clear of the edge.
  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  // Watchdog: if the run stalls, report it and stop.
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    result_t r;
    n_cmp   = 0;
    n_bad   = 0;
    clk_run = 1'b0;
    rst     = 1'b0;
    apply(0, 0, 0);

    corners[0] = '{a: 4'd15, b: 4'd15, cin: 1'b1, exp_s: 4'd15, exp_cout: 1'b1};
    corners[1] = '{a: 4'd15, b: 4'd0,  cin: 1'b1, exp_s: 4'd0,  exp_cout: 1'b1};
    corners[2] = '{a: 4'd0,  b: 4'd0,  cin: 1'b0, exp_s: 4'd0,  exp_cout: 1'b0};
    corners[3] = '{a: 4'd8,  b: 4'd7,  cin: 1'b0, exp_s: 4'd15, exp_cout: 1'b0};
    corners[4] = '{a: 4'd7,  b: 4'd1,  cin: 1'b0, exp_s: 4'd8,  exp_cout: 1'b0};
    corners[5] = '{a: 4'd8,  b: 4'd8,  cin: 1'b0, exp_s: 4'd0,  exp_cout: 1'b1};

    // Asynchronous reset with no clock: the registered outputs clear at once.
    #1 rst = 1'b1;
    #1;
    chk_regs("reset", 4'd0, 1'b0, 1'b0, 1'b0);

    // Exhaustive combinational sweep with the clock idle.
    for (int i = 0; i < (1 << (2*N+1)); i++) begin
      apply(N'(i >> (N+1)), N'(i >> 1), i[0]);
      #1;
      chk("sweep", 32'({cout, s}), 32'(int'(a) + int'(b) + int'(cin)));
    end

    // Corner vectors.
    for (int i = 0; i < 6; i++) begin
      apply(corners[i].a, corners[i].b, corners[i].cin);
      #1;
      chk("corner.s",    32'(s),    32'(corners[i].exp_s));
      chk("corner.cout", 32'(cout), 32'(corners[i].exp_cout));
    end

    // Registered path.
    rst     = 1'b0;
    clk_run = 1'b1;
    apply(7, 1, 0);
    edge_sample();
    chk_regs("reg_7_1", 4'd8, 1'b0, 1'b1, 1'b0);
    apply(15, 1, 0);
    edge_sample();
    chk_regs("reg_15_1", 4'd0, 1'b1, 1'b0, 1'b1);
    apply(0, 0, 0);
    edge_sample();
    chk_regs("reg_0_0", 4'd0, 1'b0, 1'b0, 1'b1);
    apply(15, 0, 1);
    edge_sample();
    chk_regs("reg_wrap", 4'd0, 1'b1, 1'b0, 1'b1);
    apply(8, 8, 0);
    edge_sample();
    chk_regs("reg_8_8", 4'd0, 1'b1, 1'b1, 1'b1);

    // Asynchronous reset between edges while s_q holds 8.
    apply(7, 1, 0);
    edge_sample();
    chk_regs("preload", 4'd8, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk_regs("async_rst", 4'd0, 1'b0, 1'b0, 1'b0);
    apply(2, 3, 0);
    #1;
    chk("rst_comb.s",    32'(s),    32'd5);
    chk("rst_comb.cout", 32'(cout), 32'd0);
    edge_sample();
    chk_regs("rst_held", 4'd0, 1'b0, 1'b0, 1'b0);

    // Reset release: nothing loads until the next rising edge.
    rst = 1'b0;
    apply(3, 4, 1);
    #1;
    chk_regs("release_wait", 4'd0, 1'b0, 1'b0, 1'b0);
    edge_sample();
    chk_regs("release_load", 4'd8, 1'b0, 1'b1, 1'b0);

    // Randomized run against the reference model.
    for (int i = 0; i < 300; i++) begin
      apply(N'($urandom_range(0, (1 << N) - 1)), N'($urandom_range(0, (1 << N) - 1)),
            1'($urandom_range(0, 1)));
      r = model(a, b, cin);
      #1;
      chk("rand.s",    32'(s),    32'(r.s));
      chk("rand.cout", 32'(cout), 32'(r.cout));
      edge_sample();
      chk_regs("rand", r.s, r.cout, r.ovf, r.zero);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
